fasta_base_streamer: RTL

- Upstream feeder for the affine Smith-Waterman aligner core.
- Takes a FASTA-formatted ASCII character stream, one byte per cycle.
- The first record is the query: its bases are packed into a query bit-vector plus a length-minus-one value.
- Every later record is a database sequence: its bases are streamed one 2-bit base per cycle with a valid strobe, and each record is followed by a forced idle gap so the aligner sees the end of the sequence.

---
 rtl/fasta_base_streamer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/fasta_base_streamer.sv
// FASTA byte stream -> packed query vector plus a stream of 2-bit database bases.
// The first record is the query. Every later record is streamed one base per cycle.
// A one-base lookahead register marks the last base of each record.
// A forced idle gap follows each record.
// Optional feature macro: AMBIG_SUB_EN (IUPAC ambiguity codes are mapped to base A).
module fasta_base_streamer #(
  parameter int MAX_QLEN   = 50,
  parameter int GAP_CYCLES = 1,
  parameter int ID_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_char_vld,
  input  logic [7:0]            i_char,
  input  logic                  i_eof,
  output logic                  o_char_rdy,
  output logic [2*MAX_QLEN-1:0] o_query,
  output logic [6:0]            o_query_length,
  output logic                  o_query_vld,
  output logic                  o_vld,
  output logic [1:0]            o_data,
  output logic                  o_seq_last,
  output logic [ID_W-1:0]       o_seq_id,
  output logic                  o_err,
  output logic                  o_done
);
  localparam int QCW = $clog2(MAX_QLEN + 1);

  typedef enum logic [2:0] {Q_WAIT, Q_HDR, Q_SEQ, DB_HDR, DB_SEQ, GAP, DONE} state_t;

  state_t                  state, nxt_state;
  logic [QCW-1:0]          qcnt, nxt_qcnt;
  logic [2*MAX_QLEN-1:0]   nxt_query;
  logic [6:0]              nxt_qlen;
  logic                    nxt_qvld;
  logic                    hold_vld, nxt_hold_vld;
  logic [1:0]              hold, nxt_hold;
  logic                    nxt_vld, nxt_last, nxt_err;
  logic [1:0]              nxt_data;
  logic [ID_W-1:0]         nxt_id;
  logic [3:0]              gcnt, nxt_gcnt;
  logic                    term_eof, nxt_term_eof;
  logic                    flush, nxt_flush;
  logic                    take_c, take_e, id_inc, ws, gt;
  logic [2:0]              bc;

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h0A) || (c == 8'h0D) || (c == 8'h20) || (c == 8'h09);
  endfunction

  // {legal, code}
  function automatic logic [2:0] base_code(input logic [7:0] c);
    case (c)
      "A", "a": return 3'b100;
      "G", "g": return 3'b101;
      "T", "t": return 3'b110;
      "C", "c": return 3'b111;
`ifdef AMBIG_SUB_EN
      "N", "n", "R", "r", "Y", "y", "K", "k", "M", "m", "S", "s",
      "W", "w", "B", "b", "D", "d", "H", "h", "V", "v": return 3'b100;
`endif
      default: return 3'b000;
    endcase
  endfunction

  assign o_char_rdy = (state != GAP) && (state != DONE);

  // Next-state: the accepted character is applied first, then eof acts on the result.
  always_comb begin
    nxt_state    = state;
    nxt_qcnt     = qcnt;
    nxt_query    = o_query;
    nxt_qlen     = o_query_length;
    nxt_qvld     = o_query_vld;
    nxt_hold_vld = hold_vld;
    nxt_hold     = hold;
    nxt_vld      = 1'b0;
    nxt_data     = o_data;
    nxt_last     = 1'b0;
    nxt_id       = o_seq_id;
    nxt_err      = o_err;
    nxt_gcnt     = gcnt;
    nxt_term_eof = term_eof;
    nxt_flush    = flush;
    id_inc       = 1'b0;
    take_c       = i_char_vld && o_char_rdy;
    take_e       = i_eof && o_char_rdy;
    bc           = base_code(i_char);
    ws           = is_ws(i_char);
    gt           = (i_char == ">");

    if (take_c) begin
      unique case (state)
        Q_WAIT: if (gt) nxt_state = Q_HDR; else if (!ws) nxt_err = 1'b1;
        Q_HDR:  if (i_char == 8'h0A) nxt_state = Q_SEQ;
        Q_SEQ: begin
          if (bc[2]) begin
            if (int'(qcnt) == MAX_QLEN) nxt_err = 1'b1;
            else begin
              nxt_query[2*int'(qcnt) +: 2] = bc[1:0];
              nxt_qcnt = qcnt + QCW'(1);
            end
          end else if (gt) begin
            nxt_qlen  = 7'(qcnt) - 7'd1;
            nxt_qvld  = 1'b1;
            nxt_state = DB_HDR;
          end else if (!ws) nxt_err = 1'b1;
        end
        DB_HDR: if (i_char == 8'h0A) nxt_state = DB_SEQ;
        DB_SEQ: begin
          if (bc[2]) begin
            if (hold_vld) begin
              nxt_vld  = 1'b1;
              nxt_data = hold;
            end
            nxt_hold     = bc[1:0];
            nxt_hold_vld = 1'b1;
          end else if (gt) begin
            if (hold_vld) begin
              nxt_vld      = 1'b1;
              nxt_data     = hold;
              nxt_last     = 1'b1;
              nxt_hold_vld = 1'b0;
              nxt_term_eof = 1'b0;
              nxt_gcnt     = '0;
              nxt_state    = GAP;
            end else begin
              id_inc    = 1'b1;
              nxt_state = DB_HDR;
            end
          end else if (!ws) nxt_err = 1'b1;
        end
        default: ;
      endcase
    end

    if (take_e) begin
      unique case (nxt_state)
        Q_WAIT, Q_HDR: begin
          nxt_err   = 1'b1;
          nxt_state = DONE;
        end
        Q_SEQ: begin
          if (nxt_qcnt == '0) nxt_err = 1'b1;
          nxt_qlen  = 7'(nxt_qcnt) - 7'd1;
          nxt_qvld  = 1'b1;
          nxt_state = DONE;
        end
        DB_HDR: nxt_state = DONE;
        DB_SEQ: begin
          if (nxt_hold_vld) begin
            // A base was already emitted this cycle: the last one leaves from GAP.
            if (nxt_vld) nxt_flush = 1'b1;
            else begin
              nxt_vld      = 1'b1;
              nxt_data     = nxt_hold;
              nxt_last     = 1'b1;
              nxt_hold_vld = 1'b0;
            end
            nxt_term_eof = 1'b1;
            nxt_gcnt     = '0;
            nxt_state    = GAP;
          end else begin
            id_inc    = 1'b1;
            nxt_state = DONE;
          end
        end
        GAP:     nxt_term_eof = 1'b1;
        default: ;
      endcase
    end

    if (state == GAP) begin
      if (flush) begin
        nxt_vld      = 1'b1;
        nxt_data     = hold;
        nxt_last     = 1'b1;
        nxt_hold_vld = 1'b0;
        nxt_flush    = 1'b0;
      end else begin
        if (gcnt == '0) id_inc = 1'b1;
        if (gcnt == 4'(GAP_CYCLES - 1)) begin
          nxt_gcnt  = '0;
          nxt_state = term_eof ? DONE : DB_HDR;
        end else nxt_gcnt = gcnt + 4'd1;
      end
    end

    if (id_inc) begin
      if (o_seq_id == '1) nxt_err = 1'b1;
      else nxt_id = o_seq_id + ID_W'(1);
    end
  end

  // State and output registers, synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= Q_WAIT;
      qcnt           <= '0;
      o_query        <= '0;
      o_query_length <= '0;
      o_query_vld    <= 1'b0;
      hold_vld       <= 1'b0;
      hold           <= '0;
      o_vld          <= 1'b0;
      o_data         <= '0;
      o_seq_last     <= 1'b0;
      o_seq_id       <= '0;
      o_err          <= 1'b0;
      o_done         <= 1'b0;
      gcnt           <= '0;
      term_eof       <= 1'b0;
      flush          <= 1'b0;
    end else begin
      state          <= nxt_state;
      qcnt           <= nxt_qcnt;
      o_query        <= nxt_query;
      o_query_length <= nxt_qlen;
      o_query_vld    <= nxt_qvld;
      hold_vld       <= nxt_hold_vld;
      hold           <= nxt_hold;
      o_vld          <= nxt_vld;
      o_data         <= nxt_data;
      o_seq_last     <= nxt_last;
      o_seq_id       <= nxt_id;
      o_err          <= nxt_err;
      o_done         <= (nxt_state == DONE);
      gcnt           <= nxt_gcnt;
      term_eof       <= nxt_term_eof;
      flush          <= nxt_flush;
    end
  end
endmodule
